// File: rtl/uart_rx_param.sv
// Parametrised UART receiver driven by an oversampling tick strobe.
// Ports:
//   i_clock        system clock, rising edge
//   i_reset        synchronous active-high reset
//   i_tick         one-cycle oversample strobe (BAUD_RATE*OVERSAMPLE)
//   i_rx           asynchronous serial line, idle high
//   o_data         last received word, held until the next frame completes
//   o_data_valid   one-cycle pulse per completed frame
//   o_parity_error parity mismatch in the last frame
//   o_frame_error  a stop bit sampled low in the last frame
//   o_busy         high whenever the receiver is not idle
module uart_rx_param #(
    parameter int unsigned NB_DATA         = 8,
    parameter int unsigned NB_STOP         = 1,
    parameter int unsigned PARITY_MODE     = 0,
    parameter int unsigned OVERSAMPLE      = 16,
    parameter int unsigned NB_TICK_COUNTER = $clog2(OVERSAMPLE),
    parameter int unsigned NB_DATA_COUNTER = $clog2(NB_DATA + 1)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_data_valid,
    output logic               o_parity_error,
    output logic               o_frame_error,
    output logic               o_busy
);

    localparam logic [NB_TICK_COUNTER-1:0] TICK_MID   = NB_TICK_COUNTER'(OVERSAMPLE / 2 - 1);
    localparam logic [NB_TICK_COUNTER-1:0] TICK_LAST  = NB_TICK_COUNTER'(OVERSAMPLE - 1);
    localparam logic [NB_TICK_COUNTER-1:0] TICK_ONE   = NB_TICK_COUNTER'(1);
    localparam logic [NB_DATA_COUNTER-1:0] BIT_LAST   = NB_DATA_COUNTER'(NB_DATA - 1);
    localparam logic [NB_DATA_COUNTER-1:0] STOP_LAST  = NB_DATA_COUNTER'(NB_STOP - 1);
    localparam logic [NB_DATA_COUNTER-1:0] BIT_ONE    = NB_DATA_COUNTER'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                     state_q, state_d;
    logic [NB_TICK_COUNTER-1:0] tick_q, tick_d;
    logic [NB_DATA_COUNTER-1:0] bit_q, bit_d;
    logic [NB_DATA-1:0]         shift_q, shift_d;
    logic                       par_acc_q, par_acc_d;
    logic                       par_err_q, par_err_d;
    logic                       frm_err_q, frm_err_d;
    logic                       done_q, done_d;
    logic                       rx_meta, rx_s;

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q        <= IDLE;
            tick_q         <= '0;
            bit_q          <= '0;
            shift_q        <= '0;
            par_acc_q      <= 1'b0;
            par_err_q      <= 1'b0;
            frm_err_q      <= 1'b0;
            done_q         <= 1'b0;
            o_data         <= '0;
            o_data_valid   <= 1'b0;
            o_parity_error <= 1'b0;
            o_frame_error  <= 1'b0;
            o_busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            par_acc_q    <= par_acc_d;
            par_err_q    <= par_err_d;
            frm_err_q    <= frm_err_d;
            done_q       <= done_d;
            o_data_valid <= done_q;
            o_busy       <= (state_d != IDLE);
            // Publish the frame one clock after the last stop sample.
            if (done_q) begin
                o_data         <= shift_q;
                o_parity_error <= par_err_q;
                o_frame_error  <= frm_err_q;
            end
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_acc_d = par_acc_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // Start detection acts on any cycle, not only on ticks.
                if (!rx_s) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end

            START: begin
                if (i_tick) begin
                    if (tick_q == TICK_MID) begin
                        if (!rx_s) begin
                            state_d   = DATA;
                            tick_d    = '0;
                            bit_d     = '0;
                            par_acc_d = 1'b0;
                            par_err_d = 1'b0;
                            frm_err_d = 1'b0;
                        end else begin
                            // Glitch: abandon without touching frame state.
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
            end

            DATA: begin
                if (i_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d    = '0;
                        shift_d   = {rx_s, shift_q[NB_DATA-1:1]};
                        bit_d     = bit_q + BIT_ONE;
                        par_acc_d = par_acc_q ^ rx_s;
                        if (bit_q == BIT_LAST) begin
                            bit_d   = '0;
                            state_d = (PARITY_MODE != 0) ? PARITY : STOP;
                        end
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
            end

            PARITY: begin
                if (i_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d    = '0;
                        par_err_d = (PARITY_MODE == 1) ? (par_acc_q ^ rx_s)
                                                       : ~(par_acc_q ^ rx_s);
                        state_d   = STOP;
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
            end

            STOP: begin
                if (i_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (!rx_s) begin
                            frm_err_d = 1'b1;
                        end
                        // Leave at mid-stop so a following start bit is not missed.
                        if (bit_q == STOP_LAST) begin
                            bit_d   = '0;
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            bit_d = bit_q + BIT_ONE;
                        end
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: four instances cover 8N1, even parity,
// odd parity and 7-bit/2-stop configurations sharing clock, tick and reset.
module tb_uart_rx_param;

    localparam int BIT_CLKS = 64;  // 16 ticks per bit, one tick every 4 clocks

    logic       clk;
    logic       rst;
    logic       tick;
    logic [3:0] rx;
    logic [7:0] data0, data1, data2;
    logic [6:0] data3;
    logic [3:0] valid, pe, fe, busy;

    int         checks;
    int         errors;
    int         vcnt [4];
    logic [3:0] vpe, vfe;
    logic [6:0] q3 [$];

    uart_rx_param #(.NB_DATA(8), .NB_STOP(1), .PARITY_MODE(0), .OVERSAMPLE(16)) u0 (
        .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_rx(rx[0]),
        .o_data(data0), .o_data_valid(valid[0]), .o_parity_error(pe[0]),
        .o_frame_error(fe[0]), .o_busy(busy[0]));

    uart_rx_param #(.NB_DATA(8), .NB_STOP(1), .PARITY_MODE(1), .OVERSAMPLE(16)) u1 (
        .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_rx(rx[1]),
        .o_data(data1), .o_data_valid(valid[1]), .o_parity_error(pe[1]),
        .o_frame_error(fe[1]), .o_busy(busy[1]));

    uart_rx_param #(.NB_DATA(8), .NB_STOP(1), .PARITY_MODE(2), .OVERSAMPLE(16)) u2 (
        .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_rx(rx[2]),
        .o_data(data2), .o_data_valid(valid[2]), .o_parity_error(pe[2]),
        .o_frame_error(fe[2]), .o_busy(busy[2]));

    uart_rx_param #(.NB_DATA(7), .NB_STOP(2), .PARITY_MODE(0), .OVERSAMPLE(16)) u3 (
        .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_rx(rx[3]),
        .o_data(data3), .o_data_valid(valid[3]), .o_parity_error(pe[3]),
        .o_frame_error(fe[3]), .o_busy(busy[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Oversample strobe: one cycle high every 4 clocks.
    initial begin
        tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    // Pulse monitor: counts valid cycles and captures flags at each pulse.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (valid[i] === 1'b1) begin
                vcnt[i] = vcnt[i] + 1;
                vpe[i]  = pe[i];
                vfe[i]  = fe[i];
            end
        end
        if (valid[3] === 1'b1) q3.push_back(data3);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame LSB first. A bad stop bit is held low across its
    // centre and released before the bit ends so the line is idle again.
    task automatic send_frame(input int inst, input logic [8:0] data, input int nbits,
                              input bit has_par, input logic par_bit,
                              input int nstop, input bit stop_bad);
        rx[inst] = 1'b0;
        idle(BIT_CLKS);
        for (int i = 0; i < nbits; i++) begin
            rx[inst] = data[i];
            idle(BIT_CLKS);
        end
        if (has_par) begin
            rx[inst] = par_bit;
            idle(BIT_CLKS);
        end
        for (int s = 0; s < nstop; s++) begin
            if (stop_bad) begin
                rx[inst] = 1'b0;
                idle(48);
                rx[inst] = 1'b1;
                idle(BIT_CLKS - 48);
            end else begin
                rx[inst] = 1'b1;
                idle(BIT_CLKS);
            end
        end
        rx[inst] = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 4'hF;
        idle(4);
        checks++; if (data0 !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data0); end
        checks++; if (valid !== 4'h0) begin errors++; $display("FAIL reset_valid: got %b expected 0000", valid); end
        checks++; if (pe !== 4'h0) begin errors++; $display("FAIL reset_parity: got %b expected 0000", pe); end
        checks++; if (fe !== 4'h0) begin errors++; $display("FAIL reset_frame: got %b expected 0000", fe); end
        checks++; if (busy !== 4'h0) begin errors++; $display("FAIL reset_busy: got %b expected 0000", busy); end
        rst = 1'b0;
        idle(8);
    endtask

    task automatic test_basic();
        int base = vcnt[0];
        fork
            send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b0);
            begin
                idle(200);
                checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL basic_busy_mid: got %b expected 1", busy[0]); end
            end
        join
        idle(16);
        checks++; if (vcnt[0] - base !== 1) begin errors++; $display("FAIL basic_pulses: got %0d expected 1", vcnt[0] - base); end
        checks++; if (data0 !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", data0); end
        checks++; if (vpe[0] !== 1'b0 || pe[0] !== 1'b0) begin errors++; $display("FAIL basic_parity: got %b expected 0", pe[0]); end
        checks++; if (vfe[0] !== 1'b0 || fe[0] !== 1'b0) begin errors++; $display("FAIL basic_frame: got %b expected 0", fe[0]); end
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b expected 0", busy[0]); end
        idle(64);
    endtask

    task automatic test_parity();
        int b1 = vcnt[1];
        int b2 = vcnt[2];
        send_frame(1, 9'h007, 8, 1'b1, 1'b1, 1, 1'b0);
        idle(32);
        checks++; if (vcnt[1] - b1 !== 1) begin errors++; $display("FAIL even_ok_pulses: got %0d expected 1", vcnt[1] - b1); end
        checks++; if (data1 !== 8'h07) begin errors++; $display("FAIL even_ok_data: got %h expected 07", data1); end
        checks++; if (vpe[1] !== 1'b0) begin errors++; $display("FAIL even_ok_perr: got %b expected 0", vpe[1]); end
        send_frame(1, 9'h007, 8, 1'b1, 1'b0, 1, 1'b0);
        idle(32);
        checks++; if (data1 !== 8'h07) begin errors++; $display("FAIL even_bad_data: got %h expected 07", data1); end
        checks++; if (vpe[1] !== 1'b1 || pe[1] !== 1'b1) begin errors++; $display("FAIL even_bad_perr: got %b expected 1", pe[1]); end
        checks++; if (fe[1] !== 1'b0) begin errors++; $display("FAIL even_bad_ferr: got %b expected 0", fe[1]); end
        send_frame(2, 9'h007, 8, 1'b1, 1'b0, 1, 1'b0);
        idle(32);
        checks++; if (vcnt[2] - b2 !== 1) begin errors++; $display("FAIL odd_pulses: got %0d expected 1", vcnt[2] - b2); end
        checks++; if (data2 !== 8'h07) begin errors++; $display("FAIL odd_data: got %h expected 07", data2); end
        checks++; if (pe[2] !== 1'b0) begin errors++; $display("FAIL odd_perr: got %b expected 0", pe[2]); end
        idle(64);
    endtask

    task automatic test_frame_error();
        int base = vcnt[0];
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1);
        idle(128);
        checks++; if (vcnt[0] - base !== 1) begin errors++; $display("FAIL ferr_pulses: got %0d expected 1", vcnt[0] - base); end
        checks++; if (data0 !== 8'h3C) begin errors++; $display("FAIL ferr_data: got %h expected 3c", data0); end
        checks++; if (vfe[0] !== 1'b1 || fe[0] !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b expected 1", fe[0]); end
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL ferr_busy: got %b expected 0", busy[0]); end
        send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b0);
        idle(32);
        checks++; if (data0 !== 8'h11) begin errors++; $display("FAIL ferr_next_data: got %h expected 11", data0); end
        checks++; if (fe[0] !== 1'b0) begin errors++; $display("FAIL ferr_next_flag: got %b expected 0", fe[0]); end
        idle(64);
    endtask

    task automatic test_glitch();
        int base = vcnt[0];
        rx[0] = 1'b0;
        idle(8);
        checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise: got %b expected 1", busy[0]); end
        idle(8);
        rx[0] = 1'b1;
        idle(100);
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL glitch_busy_fall: got %b expected 0", busy[0]); end
        checks++; if (vcnt[0] - base !== 0) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", vcnt[0] - base); end
        checks++; if (data0 !== 8'h11) begin errors++; $display("FAIL glitch_data: got %h expected 11", data0); end
        idle(64);
    endtask

    task automatic test_reset_mid_frame();
        int base = vcnt[0];
        fork
            send_frame(0, 9'h0FF, 8, 1'b0, 1'b0, 1, 1'b0);
            begin
                idle(4 * BIT_CLKS + 32);  // middle of data bit 3
                rst = 1'b1;
                idle(1);
                rst = 1'b0;
                checks++; if (data0 !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected 00", data0); end
                checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy[0]); end
                checks++; if (valid[0] !== 1'b0 || pe[0] !== 1'b0 || fe[0] !== 1'b0) begin
                    errors++; $display("FAIL rstmid_flags: got v%b p%b f%b expected 000", valid[0], pe[0], fe[0]);
                end
            end
        join
        idle(64);
        checks++; if (vcnt[0] - base !== 0) begin errors++; $display("FAIL rstmid_pulses: got %0d expected 0", vcnt[0] - base); end
        send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b0);
        idle(32);
        checks++; if (vcnt[0] - base !== 1) begin errors++; $display("FAIL rstmid_next_pulses: got %0d expected 1", vcnt[0] - base); end
        checks++; if (data0 !== 8'h5A) begin errors++; $display("FAIL rstmid_next_data: got %h expected 5a", data0); end
        idle(64);
    endtask

    task automatic test_back_to_back();
        int base = vcnt[3];
        q3.delete();
        send_frame(3, 9'h001, 7, 1'b0, 1'b0, 2, 1'b0);
        send_frame(3, 9'h07E, 7, 1'b0, 1'b0, 2, 1'b0);
        idle(64);
        checks++; if (vcnt[3] - base !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", vcnt[3] - base); end
        checks++; if (q3.size() < 1 || q3[0] !== 7'h01) begin errors++; $display("FAIL b2b_first: got %h expected 01 (captured %0d)", (q3.size() > 0) ? q3[0] : 7'h7F, q3.size()); end
        checks++; if (q3.size() < 2 || q3[1] !== 7'h7E) begin errors++; $display("FAIL b2b_second: got %h expected 7e (captured %0d)", (q3.size() > 1) ? q3[1] : 7'h7F, q3.size()); end
        checks++; if (data3 !== 7'h7E) begin errors++; $display("FAIL b2b_data_held: got %h expected 7e", data3); end
        checks++; if (pe[3] !== 1'b0 || fe[3] !== 1'b0) begin errors++; $display("FAIL b2b_errors: got p%b f%b expected 00", pe[3], fe[3]); end
        checks++; if (busy[3] !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b expected 0", busy[3]); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vpe    = 4'h0;
        vfe    = 4'h0;
        rst    = 1'b1;
        rx     = 4'hF;
        for (int i = 0; i < 4; i++) vcnt[i] = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_parity();
        test_frame_error();
        test_glitch();
        test_reset_mid_frame();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
